// File: rtl/ram_req_ctrl_pkg.sv
// Shared types for the load/store request controller.
//   word_t           32-bit data word
//   ram_state_t      status reported by the RAM wrapper
//   mem_width_t      access size requested by the core
//   ram_ctrl_state_t controller FSM states
package ram_req_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RAM_FREE  = 2'b00,
        RAM_ADDR  = 2'b01,
        RAM_DATA  = 2'b10,
        RAM_ERROR = 2'b11
    } ram_state_t;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } ram_ctrl_state_t;

    // Illegal width or an address not naturally aligned to the access size.
    function automatic logic access_fault(mem_width_t width, logic [1:0] addr_lo);
        case (width)
            BYTE:    return 1'b0;
            HALF:    return addr_lo[0];
            WORD:    return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ram_req_ctrl_if.sv
// Bus bundle between core, request controller and RAM wrapper.
//   master : core side (drives requests, receives responses)
//   slave  : request controller
//   ram    : RAM wrapper side
interface ram_req_ctrl_if #(
    parameter int ADDR_W = 32
);
    import ram_req_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    word_t             req_wdata;
    logic [1:0]        req_width;
    logic              req_unsigned;

    logic              resp_valid;
    word_t             resp_rdata;
    logic              resp_err;

    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    word_t             ram_store;
    logic [1:0]        ram_width;
    ram_state_t        ram_state;
    word_t             ram_load;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_width, req_unsigned,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_width, req_unsigned,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ram_ren, ram_wen, ram_addr, ram_store, ram_width,
        input  ram_state, ram_load
    );

    modport ram (
        input  ram_ren, ram_wen, ram_addr, ram_store, ram_width,
        output ram_state, ram_load
    );

endinterface

// File: rtl/ram_req_ctrl_lane_align.sv
// Lane handling shared by the load and read-modify-write paths.
//   i_word     word read from RAM
//   i_off      byte offset of the access within the word
//   i_width    access size
//   i_unsigned zero-extend (1) or sign-extend (0) sub-word loads
//   i_wdata    right-justified store data
//   o_load     extracted and extended load value
//   o_merged   i_word with the addressed lane(s) replaced by i_wdata
module ram_lane_align
    import ram_req_ctrl_pkg::*;
(
    input  word_t      i_word,
    input  logic [1:0] i_off,
    input  mem_width_t i_width,
    input  logic       i_unsigned,
    input  word_t      i_wdata,
    output word_t      o_load,
    output word_t      o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = i_word[{i_off, 3'b000} +: 8];
        w_half   = i_word[{i_off[1], 4'b0000} +: 16];
        o_load   = i_word;
        o_merged = i_wdata;
        case (i_width)
            BYTE: begin
                o_load   = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_merged = i_word;
                o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
            end
            HALF: begin
                o_load   = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_merged = i_word;
                o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// Load/store request controller in front of the RAM wrapper.
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  slave side of ram_req_ctrl_if (core handshake + RAM request lines)
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// READ  | ram_ren held until RAM_DATA (load, or first half of a sub-word store)
// WRITE | ram_wen held with the full/merged word until RAM_DATA
// RESP  | one-cycle resp_valid pulse
module ram_req_ctrl
    import ram_req_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic           clk,
    input  logic           rst,
    ram_req_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    ram_ctrl_state_t   r_state, w_state;
    logic [1:0]        r_off, w_off;
    mem_width_t        r_width, w_width;
    logic              r_store, w_store;
    logic              r_uns, w_uns;
    word_t             r_wdata, w_wdata;
    logic              r_ram_ren, w_ram_ren;
    logic              r_ram_wen, w_ram_wen;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
    word_t             r_ram_store, w_ram_store;
    word_t             r_rdata, w_rdata;
    logic              r_err, w_err;
    logic [CNT_W-1:0]  r_cnt, w_cnt;

    mem_width_t        w_req_width;
    logic              w_cnt_done;
    word_t             w_lane_load;
    word_t             w_lane_merged;

    ram_lane_align u_lane (
        .i_word     (bus.ram_load),
        .i_off      (r_off),
        .i_width    (r_width),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .o_load     (w_lane_load),
        .o_merged   (w_lane_merged)
    );

    assign w_req_width = mem_width_t'(bus.req_width);
    // The counter has already counted TIMEOUT-1 waiting cycles; this is the last one.
    assign w_cnt_done  = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_off       <= 2'b00;
            r_width     <= BYTE;
            r_store     <= 1'b0;
            r_uns       <= 1'b0;
            r_wdata     <= '0;
            r_ram_ren   <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_store <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state;
            r_off       <= w_off;
            r_width     <= w_width;
            r_store     <= w_store;
            r_uns       <= w_uns;
            r_wdata     <= w_wdata;
            r_ram_ren   <= w_ram_ren;
            r_ram_wen   <= w_ram_wen;
            r_ram_addr  <= w_ram_addr;
            r_ram_store <= w_ram_store;
            r_rdata     <= w_rdata;
            r_err       <= w_err;
            r_cnt       <= w_cnt;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_off       = r_off;
        w_width     = r_width;
        w_store     = r_store;
        w_uns       = r_uns;
        w_wdata     = r_wdata;
        w_ram_ren   = r_ram_ren;
        w_ram_wen   = r_ram_wen;
        w_ram_addr  = r_ram_addr;
        w_ram_store = r_ram_store;
        w_rdata     = r_rdata;
        w_err       = r_err;
        w_cnt       = r_cnt;

        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_off      = bus.req_addr[1:0];
                    w_width    = w_req_width;
                    w_store    = bus.req_wen;
                    w_uns      = bus.req_unsigned;
                    w_wdata    = bus.req_wdata;
                    w_ram_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    w_rdata    = '0;
                    w_err      = 1'b0;
                    w_cnt      = '0;
                    if (access_fault(w_req_width, bus.req_addr[1:0])) begin
                        w_err   = 1'b1;
                        w_state = RESP;
                    end else if (bus.req_wen && (w_req_width == WORD)) begin
                        w_ram_wen   = 1'b1;
                        w_ram_store = bus.req_wdata;
                        w_state     = WRITE;
                    end else begin
                        // Sub-word stores read first because RAM byte enables are fixed.
                        w_ram_ren = 1'b1;
                        w_state   = READ;
                    end
                end
            end
            READ: begin
                if (bus.ram_state == RAM_ERROR) begin
                    w_ram_ren = 1'b0;
                    w_err     = 1'b1;
                    w_state   = RESP;
                end else if (bus.ram_state == RAM_DATA) begin
                    w_ram_ren = 1'b0;
                    if (r_store) begin
                        w_ram_wen   = 1'b1;
                        w_ram_store = w_lane_merged;
                        w_cnt       = '0;
                        w_state     = WRITE;
                    end else begin
                        w_rdata = w_lane_load;
                        w_state = RESP;
                    end
                end else if (w_cnt_done) begin
                    w_ram_ren = 1'b0;
                    w_err     = 1'b1;
                    w_state   = RESP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            WRITE: begin
                if (bus.ram_state == RAM_ERROR) begin
                    w_ram_wen = 1'b0;
                    w_err     = 1'b1;
                    w_state   = RESP;
                end else if (bus.ram_state == RAM_DATA) begin
                    w_ram_wen = 1'b0;
                    w_state   = RESP;
                end else if (w_cnt_done) begin
                    w_ram_wen = 1'b0;
                    w_err     = 1'b1;
                    w_state   = RESP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            RESP: begin
                w_err   = 1'b0;
                w_rdata = '0;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_err   = r_err;
    assign bus.resp_rdata = r_rdata;
    assign bus.ram_ren    = r_ram_ren;
    assign bus.ram_wen    = r_ram_wen;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_store  = r_ram_store;
    assign bus.ram_width  = WORD;

endmodule

// File: tb/tb_ram_req_ctrl.sv
module tb_ram_req_ctrl;
    import ram_req_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_req_ctrl_if #(.ADDR_W(32)) bus ();

    ram_req_ctrl #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // RAM stub with zero latency: a request seen in RAM_FREE answers RAM_DATA next cycle.
    word_t      mem [64];
    ram_state_t stub_st = RAM_FREE;
    logic [31:0] stub_addr = '0;
    bit         stub_hang = 0;
    bit         stub_err = 0;
    int         rd_count = 0;
    int         wr_count = 0;
    word_t      last_wr_data = '0;
    logic [31:0] last_wr_addr = '0;
    bit         proto_bad = 0;

    assign bus.ram_state = stub_st;
    assign bus.ram_load  = mem[stub_addr[7:2]];

    always @(posedge clk) begin
        if (bus.ram_ren && bus.ram_wen) proto_bad <= 1;
        if ((bus.ram_ren || bus.ram_wen) && (bus.ram_addr[1:0] != 2'b00 || bus.ram_width != 2'b10))
            proto_bad <= 1;
        if (rst) begin
            stub_st <= RAM_FREE;
        end else begin
            case (stub_st)
                RAM_FREE: if (bus.ram_ren || bus.ram_wen) begin
                    stub_addr <= bus.ram_addr;
                    if (stub_hang) stub_st <= RAM_ADDR;
                    else if (stub_err) stub_st <= RAM_ERROR;
                    else begin
                        stub_st <= RAM_DATA;
                        if (bus.ram_wen) begin
                            wr_count     <= wr_count + 1;
                            last_wr_data <= bus.ram_store;
                            last_wr_addr <= bus.ram_addr;
                        end else begin
                            rd_count <= rd_count + 1;
                        end
                    end
                end
                RAM_ADDR: if (!(bus.ram_ren || bus.ram_wen)) stub_st <= RAM_FREE;
                default:  stub_st <= RAM_FREE;
            endcase
        end
    end

    // Reference: what one access should do to a RAM word, from the access rules alone.
    function automatic void model(input word_t old, input logic [31:0] a, input logic [1:0] w,
                                  input bit wen, input bit uns, input word_t wd,
                                  output bit e, output word_t rd, output word_t nw,
                                  output int lat, output int nrd, output int nwr);
        int nb;
        int sh;
        word_t mask;
        word_t v;
        nb = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        e = 0; rd = 0; nw = old; lat = 1; nrd = 0; nwr = 0;
        if (w == 2'd3 || (a % nb) != 0) begin
            e = 1;
            return;
        end
        sh   = int'(a % 4) * 8;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        if (!wen) begin
            v = (old >> sh) & mask;
            if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
            rd = v; lat = 3; nrd = 1;
        end else begin
            nw  = (old & ~(mask << sh)) | ((wd & mask) << sh);
            lat = (nb == 4) ? 3 : 5;
            nrd = (nb == 4) ? 0 : 1;
            nwr = 1;
        end
    endfunction

    task automatic do_access(input logic [31:0] a, input logic [1:0] w, input bit wen,
                             input bit uns, input word_t wd,
                             output bit t_err, output word_t t_rd, output int t_lat,
                             output bit t_rdy0, output bit t_rdy_resp, output int t_ren_cyc,
                             output bit t_to);
        int c;
        bit done;
        @(posedge clk); #1;
        t_rdy0 = bus.req_ready;
        bus.req_valid = 1; bus.req_addr = a; bus.req_width = w;
        bus.req_wen = wen; bus.req_unsigned = uns; bus.req_wdata = wd;
        @(posedge clk); #1;
        // Inputs are don't-care after acceptance; scramble them.
        bus.req_valid = 0; bus.req_addr = $urandom; bus.req_width = 2'($urandom);
        bus.req_wen = 1'($urandom); bus.req_unsigned = 1'($urandom); bus.req_wdata = $urandom;
        t_to = 1; t_lat = 0; t_err = 0; t_rd = 0; t_rdy_resp = 0; t_ren_cyc = 0;
        c = 1; done = 0;
        while (!done && c <= 40) begin
            if (bus.ram_ren) t_ren_cyc++;
            if (bus.resp_valid) begin
                t_lat = c; t_err = bus.resp_err; t_rd = bus.resp_rdata;
                t_rdy_resp = bus.req_ready; t_to = 0; done = 1;
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] got [8];
        logic [31:0] exp [8];
        string nm [8];
        rst = 1; bus.req_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        got = '{32'(bus.req_ready), 32'(bus.resp_valid), 32'(bus.resp_err), bus.resp_rdata,
                32'(bus.ram_ren), 32'(bus.ram_wen), bus.ram_addr, bus.ram_store};
        exp = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        nm  = '{"req_ready", "resp_valid", "resp_err", "resp_rdata", "ram_ren", "ram_wen", "ram_addr", "ram_store"};
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (got[i] !== exp[i]) begin
                n_err++;
                $display("FAIL reset_%s got %0h want %0h", nm[i], got[i], exp[i]);
            end
        end
        rst = 0;
    endtask

    task automatic test_directed();
        bit e, r0, rr, to; word_t rd; int lat, rc, rd0, wr0;
        mem[4] = 32'h80FF_1234;

        do_access(32'h13, 2'b00, 0, 0, 32'h0, e, rd, lat, r0, rr, rc, to);
        n_vec++; if (rd !== 32'hFFFF_FF80 || e !== 0) begin n_err++; $display("FAIL lb_signed got %h err %0d want ffffff80 err 0", rd, e); end
        n_vec++; if (lat !== 3 || rc !== 2) begin n_err++; $display("FAIL lb_timing got lat %0d ren %0d want 3 2", lat, rc); end
        n_vec++; if (rr !== 0 || r0 !== 1) begin n_err++; $display("FAIL lb_ready got acc %0d resp %0d want 1 0", r0, rr); end

        do_access(32'h13, 2'b00, 0, 1, 32'h0, e, rd, lat, r0, rr, rc, to);
        n_vec++; if (rd !== 32'h0000_0080 || e !== 0) begin n_err++; $display("FAIL lbu got %h err %0d want 00000080 err 0", rd, e); end

        rd0 = rd_count; wr0 = wr_count;
        do_access(32'h11, 2'b00, 1, 0, 32'hAB, e, rd, lat, r0, rr, rc, to);
        n_vec++; if (lat !== 5 || e !== 0 || rd !== 0) begin n_err++; $display("FAIL sb_resp got lat %0d err %0d rd %h want 5 0 0", lat, e, rd); end
        n_vec++; if (rd_count - rd0 !== 1 || wr_count - wr0 !== 1) begin n_err++; $display("FAIL sb_ops got rd %0d wr %0d want 1 1", rd_count - rd0, wr_count - wr0); end
        n_vec++; if (last_wr_data !== 32'h80FF_AB34 || last_wr_addr !== 32'h10) begin n_err++; $display("FAIL sb_data got %h @%h want 80ffab34 @10", last_wr_data, last_wr_addr); end
        n_vec++; if (proto_bad !== 0) begin n_err++; $display("FAIL sb_proto got %0d want 0", proto_bad); end
        mem[4] = 32'h80FF_AB34;

        do_access(32'h12, 2'b01, 0, 0, 32'h0, e, rd, lat, r0, rr, rc, to);
        n_vec++; if (rd !== 32'hFFFF_80FF || lat !== 3) begin n_err++; $display("FAIL lh_signed got %h lat %0d want ffff80ff 3", rd, lat); end

        rd0 = rd_count;
        do_access(32'h12, 2'b10, 0, 0, 32'h0, e, rd, lat, r0, rr, rc, to);
        n_vec++; if (e !== 1 || lat !== 1 || rd !== 0) begin n_err++; $display("FAIL lw_misalign got err %0d lat %0d rd %h want 1 1 0", e, lat, rd); end
        n_vec++; if (rc !== 0 || rd_count !== rd0) begin n_err++; $display("FAIL lw_misalign_ren got %0d want 0", rc); end
        @(posedge clk); #1;
        n_vec++; if (bus.resp_valid !== 0 || bus.req_ready !== 1) begin n_err++; $display("FAIL resp_pulse got valid %0d ready %0d want 0 1", bus.resp_valid, bus.req_ready); end
    endtask

    task automatic test_ram_error();
        bit e, r0, rr, to; word_t rd; int lat, rc, wr0;
        stub_err = 1; wr0 = wr_count;
        do_access(32'h20, 2'b10, 0, 0, 32'h0, e, rd, lat, r0, rr, rc, to);
        n_vec++; if (e !== 1 || lat !== 3 || rd !== 0) begin n_err++; $display("FAIL ramerr_load got err %0d lat %0d rd %h want 1 3 0", e, lat, rd); end
        do_access(32'h24, 2'b10, 1, 0, 32'h1234_5678, e, rd, lat, r0, rr, rc, to);
        n_vec++; if (e !== 1 || lat !== 3 || wr_count !== wr0) begin n_err++; $display("FAIL ramerr_store got err %0d lat %0d writes %0d want 1 3 0", e, lat, wr_count - wr0); end
        stub_err = 0;
    endtask

    task automatic test_timeout();
        bit e, r0, rr, to; word_t rd; int lat, rc;
        stub_hang = 1;
        do_access(32'h20, 2'b10, 0, 0, 32'h0, e, rd, lat, r0, rr, rc, to);
        n_vec++; if (to !== 0 || rc !== 16 || lat !== 17) begin n_err++; $display("FAIL timeout_len got ren %0d lat %0d expired %0d want 16 17 0", rc, lat, to); end
        n_vec++; if (e !== 1) begin n_err++; $display("FAIL timeout_err got %0d want 1", e); end
        @(posedge clk); #1;
        n_vec++; if (bus.req_ready !== 1 || bus.ram_ren !== 0) begin n_err++; $display("FAIL timeout_idle got ready %0d ren %0d want 1 0", bus.req_ready, bus.ram_ren); end
        stub_hang = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int wr0;
        bit seen;
        logic [31:0] got [8];
        logic [31:0] exp [8];
        string nm [8];
        wr0 = wr_count; seen = 0;
        @(posedge clk); #1;
        bus.req_valid = 1; bus.req_addr = 32'h15; bus.req_width = 2'b00;
        bus.req_wen = 1; bus.req_unsigned = 0; bus.req_wdata = 32'h5A;
        @(posedge clk); #1;
        bus.req_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        got = '{32'(bus.req_ready), 32'(bus.resp_valid), 32'(bus.resp_err), bus.resp_rdata,
                32'(bus.ram_ren), 32'(bus.ram_wen), bus.ram_addr, bus.ram_store};
        exp = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        nm  = '{"req_ready", "resp_valid", "resp_err", "resp_rdata", "ram_ren", "ram_wen", "ram_addr", "ram_store"};
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (got[i] !== exp[i]) begin
                n_err++;
                $display("FAIL midrst_%s got %0h want %0h", nm[i], got[i], exp[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (bus.resp_valid || bus.ram_wen) seen = 1;
            @(posedge clk); #1;
        end
        n_vec++; if (seen !== 0 || wr_count !== wr0) begin n_err++; $display("FAIL midrst_quiet got activity %0d writes %0d want 0 0", seen, wr_count - wr0); end
    endtask

    task automatic test_random();
        bit e, r0, rr, to; word_t rd; int lat, rc, rd0, wr0;
        bit xe; word_t xrd, xnw; int xlat, xnrd, xnwr;
        logic [31:0] a; logic [1:0] w; bit wen, uns; word_t wd; int idx;
        for (int n = 0; n < 150; n++) begin
            a   = 32'($urandom_range(0, 255));
            w   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) a = (w == 2'd2) ? (a & ~32'd3) : (w == 2'd1) ? (a & ~32'd1) : a;
            wen = 1'($urandom); uns = 1'($urandom); wd = $urandom;
            idx = int'(a[7:2]);
            model(mem[idx], a, w, wen, uns, wd, xe, xrd, xnw, xlat, xnrd, xnwr);
            rd0 = rd_count; wr0 = wr_count;
            do_access(a, w, wen, uns, wd, e, rd, lat, r0, rr, rc, to);
            n_vec++;
            if (e !== xe || rd !== xrd || lat !== xlat || to !== 0) begin
                n_err++;
                $display("FAIL rand_resp a=%h w=%0d wen=%0d uns=%0d got err %0d rd %h lat %0d want %0d %h %0d", a, w, wen, uns, e, rd, lat, xe, xrd, xlat);
            end
            n_vec++;
            if (rd_count - rd0 !== xnrd || wr_count - wr0 !== xnwr || r0 !== 1 || rr !== 0) begin
                n_err++;
                $display("FAIL rand_ops a=%h got rd %0d wr %0d want %0d %0d", a, rd_count - rd0, wr_count - wr0, xnrd, xnwr);
            end
            if (xnwr == 1) begin
                n_vec++;
                if (last_wr_data !== xnw || last_wr_addr !== (a & ~32'd3)) begin
                    n_err++;
                    $display("FAIL rand_wdata a=%h got %h @%h want %h", a, last_wr_data, last_wr_addr, xnw);
                end
            end
            mem[idx] = xnw;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        n_vec++; if (proto_bad !== 0) begin n_err++; $display("FAIL ram_protocol got %0d want 0", proto_bad); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        bus.req_valid = 0; bus.req_addr = 0; bus.req_width = 0;
        bus.req_wen = 0; bus.req_unsigned = 0; bus.req_wdata = 0;
        test_reset();
        test_directed();
        test_ram_error();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
